// File: rtl/spi_burst_ctrl_pkg.sv
// Shared constants for the SPI burst sequencer: FSM state encodings, byte width, clog2 helper.
package spi_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Byte stream, SPI master handshake and framing signals of the burst sequencer.
// master = sequencer view, slave = surrounding logic (producer, consumer, byte-level SPI master).
interface spi_burst_ctrl_if;
  import spi_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [BYTE_W-1:0] m_mosi_in;
  logic              m_start;
  logic [BYTE_W-1:0] m_miso_out;
  logic              m_done;
  logic              cs_n;
  logic              busy;

  modport master (
    input  tx_data, tx_last, tx_valid, rx_ready, m_miso_out, m_done,
    output tx_ready, rx_data, rx_valid, m_mosi_in, m_start, cs_n, busy
  );

  modport slave (
    output tx_data, tx_last, tx_valid, rx_ready, m_miso_out, m_done,
    input  tx_ready, rx_data, rx_valid, m_mosi_in, m_start, cs_n, busy
  );

endinterface

// File: rtl/spi_burst_ctrl_fifo.sv
// Synchronous FIFO, 1-cycle first-word latency; push while full is accepted only with a same-cycle pop.
// Full/empty come from extra-MSB pointer comparison on registered pointers.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI burst sequencer: TX/RX byte FIFOs, one m_start per byte, cs_n framing per tx_last burst; starts stall while RX is full.
// Optional SPI_BURST_COUNT_EN adds a saturating byte_count of completed transfers.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_burst_ctrl_if.master       bus
`ifdef SPI_BURST_COUNT_EN
  ,
  output logic [15:0]            byte_count
`endif
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cs_n_q, cs_n_d;
  logic              last_q, last_d;
  logic [BYTE_W-1:0] mosi_q, mosi_d;

  logic [BYTE_W:0]   tx_head;
  logic              tx_full, tx_empty, tx_push;
  logic [BYTE_W-1:0] rx_head;
  logic              rx_full, rx_empty, rx_push;
  logic              rx_space;
  logic              start_go;

  assign tx_push  = bus.tx_valid && !tx_full;
  assign rx_push  = (state_q == ST_WAIT) && bus.m_done;
  // A consumer pop in the same cycle frees a slot before the byte returns.
  assign rx_space = !rx_full || bus.rx_ready;
  assign start_go = (state_q == ST_START) && !tx_empty && rx_space;

  spi_sync_fifo #(.WIDTH(BYTE_W + 1), .DEPTH(DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tx_push),
    .push_dat_i ({bus.tx_last, bus.tx_data}),
    .pop_i      (start_go),
    .head_dat_o (tx_head),
    .full_o     (tx_full),
    .empty_o    (tx_empty)
  );

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rx_push),
    .push_dat_i (bus.m_miso_out),
    .pop_i      (bus.rx_ready),
    .head_dat_o (rx_head),
    .full_o     (rx_full),
    .empty_o    (rx_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    last_d  = last_q;
    mosi_d  = mosi_q;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          cs_n_d  = 1'b0;
          cnt_d   = CNT_W'(CS_SETUP - 1);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) state_d = ST_START;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_START: begin
        if (start_go) begin
          mosi_d  = tx_head[BYTE_W-1:0];
          last_d  = tx_head[BYTE_W];
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.m_done) begin
          if (last_q) begin
            cnt_d   = CNT_W'(CS_HOLD - 1);
            state_d = ST_HOLD;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      last_q  <= 1'b0;
      mosi_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      last_q  <= last_d;
      mosi_q  <= mosi_d;
    end
  end

  // m_start is decoded from registered state so the byte reaches the master the cycle START qualifies.
  assign bus.m_start   = start_go;
  assign bus.m_mosi_in = start_go ? tx_head[BYTE_W-1:0] : mosi_q;
  assign bus.tx_ready  = !tx_full;
  assign bus.rx_valid  = !rx_empty;
  assign bus.rx_data   = rx_head;
  assign bus.cs_n      = cs_n_q;
  assign bus.busy      = (state_q != ST_IDLE);

`ifdef SPI_BURST_COUNT_EN
  logic [15:0] byte_count_q, byte_count_d;

  always_comb begin
    byte_count_d = byte_count_q;
    if (rx_push && (byte_count_q != 16'hFFFF)) byte_count_d = byte_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) byte_count_q <= '0;
    else     byte_count_q <= byte_count_d;
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl: vector table plus hand-written corner sequences,
// with an SPI master model and mosi/rx scoreboards.
module tb_spi_burst_ctrl;

  localparam int DEPTH    = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_burst_ctrl_if bus ();

`ifdef SPI_BURST_COUNT_EN
  logic [15:0] byte_count;
`endif

  spi_burst_ctrl #(.DEPTH(DEPTH), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SPI_BURST_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [7:0] rx;
  } vec_t;

  vec_t tbl [7];

  int errors = 0;
  int checks = 0;

  logic [7:0] mosi_q [$];
  logic [7:0] rx_q [$];

  bit         master_en = 1'b1;
  int         resp_mode = 1;
  bit         stray_req = 1'b0;
  bit         md_pending = 1'b0;
  int         md_cnt = 0;
  logic [7:0] md_resp = 8'h00;

  int cyc = 0;
  int start_cnt = 0;
  int rise_cnt = 0;
  int last_start_cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int done_cyc = -1000;
  int min_gap = 1000;
  logic prev_cs = 1'b1;
  logic prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation or bound expired", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, consumer scoreboard and SPI master model, all sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.cs_n !== prev_cs) begin
      if (bus.cs_n) begin
        rise_cnt++;
        rise_cyc = cyc;
      end else begin
        fall_cyc = cyc;
      end
    end
    prev_cs = bus.cs_n;

    if (bus.m_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (cyc - done_cyc < min_gap) min_gap = cyc - done_cyc;
      chk("cs_n_at_start", {31'd0, bus.cs_n}, 32'd0);
      chk("start_pulse_width", {31'd0, prev_start}, 32'd0);
      if (mosi_q.size() == 0) fail_now("mosi_unexpected_start");
      else chk("m_mosi_in", {24'd0, bus.m_mosi_in}, {24'd0, mosi_q.pop_front()});
    end
    prev_start = bus.m_start;

    if (bus.rx_valid && bus.rx_ready) begin
      if (rx_q.size() == 0) fail_now("rx_unexpected_byte");
      else chk("rx_data", {24'd0, bus.rx_data}, {24'd0, rx_q.pop_front()});
    end

    bus.m_done = 1'b0;
    if (rst) begin
      md_pending = 1'b0;
    end else if (stray_req) begin
      bus.m_done     = 1'b1;
      bus.m_miso_out = 8'h5A;
      stray_req      = 1'b0;
    end else if (md_pending && master_en) begin
      if (md_cnt == 0) begin
        bus.m_done     = 1'b1;
        bus.m_miso_out = md_resp;
        md_pending     = 1'b0;
        done_cyc       = cyc;
      end else begin
        md_cnt--;
      end
    end
    if (bus.m_start && !rst) begin
      md_pending = 1'b1;
      md_cnt     = 1;
      md_resp    = (resp_mode == 0) ? 8'h3C : bus.m_mosi_in + 8'h10;
    end
  end

  task automatic push(input logic [7:0] d, input logic l, input logic [7:0] exp_rx);
    int n;
    n = 0;
    bus.tx_data  = d;
    bus.tx_last  = l;
    bus.tx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_ready && n < 200);
    if (bus.tx_ready) begin
      mosi_q.push_back(d);
      rx_q.push_back(exp_rx);
    end else begin
      fail_now("tx_ready_timeout");
    end
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((mosi_q.size() != 0 || rx_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, (mosi_q.size() == 0 && rx_q.size() == 0 && !bus.busy)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    int n;

    tbl[0] = '{d: 8'h01, l: 1'b0, rx: 8'h11};
    tbl[1] = '{d: 8'h02, l: 1'b0, rx: 8'h12};
    tbl[2] = '{d: 8'h03, l: 1'b1, rx: 8'h13};
    tbl[3] = '{d: 8'hFF, l: 1'b1, rx: 8'h0F};
    tbl[4] = '{d: 8'h7E, l: 1'b0, rx: 8'h8E};
    tbl[5] = '{d: 8'h80, l: 1'b1, rx: 8'h90};
    tbl[6] = '{d: 8'h3F, l: 1'b1, rx: 8'h4F};

    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    bus.rx_ready = 1'b1;
    do_reset();

    @(negedge clk);
    chk("reset_cs_n", {31'd0, bus.cs_n}, 32'd1);
    chk("reset_m_start", {31'd0, bus.m_start}, 32'd0);
    chk("reset_m_mosi_in", {24'd0, bus.m_mosi_in}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Single byte: fixed response, framing timing.
    resp_mode = 0;
    s0 = start_cnt;
    push(8'hA5, 1'b1, 8'h3C);
    wait_drain("single_drain", 100);
    chk("single_starts", start_cnt - s0, 32'd1);
    chk("single_setup_cycles", last_start_cyc - fall_cyc, CS_SETUP);
    chk("single_hold_cycles", rise_cyc - done_cyc, CS_HOLD + 1);
    chk("single_cs_n_idle", {31'd0, bus.cs_n}, 32'd1);

    // Vector table: four bursts, echo +0x10.
    resp_mode = 1;
    s0 = start_cnt;
    r0 = rise_cnt;
    min_gap = 1000;
    for (int i = 0; i < 7; i++) push(tbl[i].d, tbl[i].l, tbl[i].rx);
    wait_drain("table_drain", 400);
    chk("table_starts", start_cnt - s0, 32'd7);
    chk("table_cs_rises", rise_cnt - r0, 32'd4);
    chk("done_to_start_min", min_gap, 32'd1);

    // RX backpressure: exactly DEPTH transfers, then stall with cs_n low.
    bus.rx_ready = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) push(8'h20 + 8'(i), (i == 9), 8'h30 + 8'(i));
    repeat (60) @(posedge clk);
    #1;
    chk("rxbp_starts_stalled", start_cnt - s0, DEPTH);
    chk("rxbp_cs_n_low", {31'd0, bus.cs_n}, 32'd0);
    chk("rxbp_busy", {31'd0, bus.busy}, 32'd1);
    chk("rxbp_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    bus.rx_ready = 1'b1;
    wait_drain("rxbp_drain", 400);
    chk("rxbp_starts_total", start_cnt - s0, 32'd10);

    // TX full: master silent, one byte in flight plus DEPTH buffered.
    master_en = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 9; i++) push(8'h40 + 8'(i), (i == 8), 8'h50 + 8'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("txfull_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
    chk("txfull_starts", start_cnt - s0, 32'd1);
    bus.tx_data  = 8'hEE;
    bus.tx_last  = 1'b1;
    bus.tx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    chk("txfull_still_full", {31'd0, bus.tx_ready}, 32'd0);
    master_en = 1'b1;
    wait_drain("txfull_drain", 400);
    chk("txfull_starts_total", start_cnt - s0, 32'd9);

    // Async reset while waiting on the second byte of a burst.
    bus.rx_ready = 1'b0;
    s0 = start_cnt;
    push(8'h61, 1'b0, 8'h71);
    push(8'h62, 1'b1, 8'h72);
    n = 0;
    while (start_cnt < s0 + 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    master_en = 1'b0;
    chk("rst_pre_starts", start_cnt - s0, 32'd2);
    chk("rst_pre_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("rst_pre_cs_n", {31'd0, bus.cs_n}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_cs_n", {31'd0, bus.cs_n}, 32'd1);
    chk("rst_async_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_async_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_async_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    mosi_q.delete();
    rx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    master_en = 1'b1;
    bus.rx_ready = 1'b1;
    stray_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("stray_done_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("stray_done_busy", {31'd0, bus.busy}, 32'd0);
    chk("stray_done_cs_n", {31'd0, bus.cs_n}, 32'd1);

`ifdef SPI_BURST_COUNT_EN
    do_reset();
    chk("count_reset", {16'd0, byte_count}, 32'd0);
    for (int i = 0; i < 7; i++) push(8'h90 + 8'(i), (i == 1 || i == 3 || i == 6), 8'hA0 + 8'(i));
    wait_drain("count_drain", 400);
    chk("count_seven", {16'd0, byte_count}, 32'd7);
    force dut.byte_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.byte_count_q;
    push(8'h55, 1'b1, 8'h65);
    wait_drain("count_sat_drain", 100);
    chk("count_saturated", {16'd0, byte_count}, 32'h0000FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
